// File: rtl/sound_player_if.sv
// Sound request / speaker status bundle between the motion logic and
// the tone sequencer.
interface sound_player_if;
    logic [1:0] code_sound;
    logic       mute;
    logic       audio;
    logic       busy;

    modport master (
        output code_sound,
        output mute,
        input  audio,
        input  busy
    );

    modport slave (
        input  code_sound,
        input  mute,
        output audio,
        output busy
    );
endinterface

// File: rtl/sound_player.sv
// Tone sequencer: plays ping, pong or go (pong then ping) as fixed-length
// square-wave notes; a code change retriggers, mute aborts at once.
module sound_player #(
    parameter int HALF_PING = 12500,
    parameter int HALF_PONG = 25000,
    parameter int NOTE_LEN  = 2500000
) (
    input  logic          clk,
    input  logic          clr,
    sound_player_if.slave snd_if
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NOTE1 = 2'd1;
    localparam logic [1:0] NOTE2 = 2'd2;

    localparam logic [1:0] CODE_STOP = 2'b00;
    localparam logic [1:0] CODE_PING = 2'b10;
    localparam logic [1:0] CODE_GO   = 2'b11;

    localparam logic [15:0] PING_LAST = 16'(HALF_PING - 1);
    localparam logic [15:0] PONG_LAST = 16'(HALF_PONG - 1);
    localparam logic [21:0] LEN_LAST  = 22'(NOTE_LEN - 1);

    logic [1:0]  code_prev_q, code_prev_d;
    logic [1:0]  snd_q, snd_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] tc_q, tc_d;
    logic [21:0] lc_q, lc_d;
    logic        audio_q, audio_d;
    logic        busy_q, busy_d;

    logic        start;
    logic [15:0] tone_last;

    // Start detection and the half-period of the note now playing.
    always_comb begin
        start = (snd_if.code_sound != code_prev_q)
             && (snd_if.code_sound != CODE_STOP);
        tone_last = PING_LAST;
        if (state_q == NOTE1 && snd_q != CODE_PING)
            tone_last = PONG_LAST;
    end

    // Next state: mute, then retrigger, then note end, then tone.
    always_comb begin
        code_prev_d = snd_if.code_sound;
        snd_d       = snd_q;
        state_d     = state_q;
        tc_d        = 16'd0;
        lc_d        = 22'd0;
        audio_d     = 1'b0;
        if (snd_if.mute) begin
            state_d = IDLE;
        end else if (start) begin
            snd_d   = snd_if.code_sound;
            state_d = NOTE1;
        end else if (state_q == IDLE) begin
            state_d = IDLE;
        end else if (lc_q == LEN_LAST) begin
            if (state_q == NOTE1 && snd_q == CODE_GO)
                state_d = NOTE2;
            else
                state_d = IDLE;
        end else begin
            lc_d = lc_q + 22'd1;
            if (tc_q == tone_last) begin
                audio_d = ~audio_q;
            end else begin
                tc_d    = tc_q + 16'd1;
                audio_d = audio_q;
            end
        end
        busy_d = (state_d != IDLE);
    end

    // State registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            code_prev_q <= 2'b00;
            snd_q       <= 2'b00;
            state_q     <= IDLE;
            tc_q        <= 16'd0;
            lc_q        <= 22'd0;
            audio_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            code_prev_q <= code_prev_d;
            snd_q       <= snd_d;
            state_q     <= state_d;
            tc_q        <= tc_d;
            lc_q        <= lc_d;
            audio_q     <= audio_d;
            busy_q      <= busy_d;
        end
    end

    assign snd_if.audio = audio_q;
    assign snd_if.busy  = busy_q;
endmodule

// File: doc/sound_player.md
# sound_player

Audio tone sequencer consuming the `mute` / `code_sound` pair published by the logo-motion block and driving a 1-bit square-wave speaker pin. A new non-silent sound code starts a fixed-length note sequence: ping (one high note), pong (one low note) or go (low note then high note). `mute` aborts any note immediately.

## Interface

- `HALF_PING`, 12500: half-period in clk cycles of the high note (1 kHz at 25 MHz); range 1..2^16-1.
- `HALF_PONG`, 25000: half-period in clk cycles of the low note (500 Hz at 25 MHz); range 1..2^16-1.
- `NOTE_LEN`, 2500000: length of one note in clk cycles (100 ms at 25 MHz); range 1..2^22-1.
- `clk`  input  1  system clock; one clock; all logic on its rising edge.
- `clr`  input  1  reset, asynchronous and active-high.
- `code_sound`  input  2  sound code: 00 stop, 01 pong, 10 ping, 11 go.
- `mute`  input  1  level; 1 silences output and aborts the sequence.
- `audio`  output  1  square-wave speaker drive, registered.
- `busy`  output  1  1 while a note sequence is playing, registered.

## Operation

- Registers: `code_prev` (2b), `snd` (2b, code being played), `state` {IDLE, NOTE1, NOTE2}, tone counter `tc` (16b), length counter `lc` (22b), `audio`.
- Reset values: `state`=IDLE, `code_prev`=00, `snd`=00, `tc`=0, `lc`=0, `audio`=0, `busy`=0.
- `code_prev` loads `code_sound` every cycle, including while muted or busy.
- Start event: `code_sound != code_prev` and `code_sound != 00`. Holding a code steady never replays it.
- Priority per edge: mute > start event > note terminal > tone toggle.
- `mute`=1: next state IDLE, `audio`=0, `tc`=`lc`=0, start events discarded. Releasing mute with an unchanged code does not start a sound.
- Start event, with `mute`=0 and any state including mid-note: `snd`<=code, state<=NOTE1, `tc`=`lc`=0, `audio`=0. This is a retrigger; the old sequence is abandoned.
- Note half-period H: NOTE1 uses HALF_PING for ping and HALF_PONG for pong/go. NOTE2 (go only) uses HALF_PING.
- Tone: `tc` counts 0..H-1. At `tc`=H-1, `tc`<=0 and `audio` toggles.
- Length: `lc` counts 0..NOTE_LEN-1. At `lc`=NOTE_LEN-1, the note ends:
  - NOTE1 with `snd`=go: go to NOTE2; `tc`, `lc`, `audio` cleared.
  - Otherwise: go to IDLE; `audio`=0.
- IDLE: counters held at 0, `audio`=0.
- `busy` = (state != IDLE), registered with state.
- Code 00 arriving mid-note does not stop the note; only `mute` or `clr` aborts.

## Timing

- Start event sampled at edge k: at edge k `busy`=1 and `audio`=0. First `audio` rise at edge k+H.
- ping/pong: `busy` high exactly NOTE_LEN cycles, falling at edge k+NOTE_LEN.
- go: NOTE2 begins at edge k+NOTE_LEN with `audio`=0. `busy` falls at edge k+2·NOTE_LEN.
- Mute asserted before edge m: `audio`=0 and `busy`=0 at edge m (one-cycle latency).
- `clr` forces all registers to reset values immediately, with no clock needed. After `clr` deasserts, a nonzero `code_sound` yields a start event at the first edge, because `code_prev`=00.
- A note cut by the length terminal forces `audio`=0 regardless of tone phase.

## Test plan

Parameters for all scenarios: HALF_PING=2, HALF_PONG=4, NOTE_LEN=16.

- **Ping:** `code_sound` 00→10 at edge 0.
  - Required: `busy`=1 for edges 0..15, 0 at edge 16.
  - Required: `audio` at edges 0..15 = 0,0,1,1,0,0,1,1,… (toggles every 2 cycles), then 0 at edge 16.
- **Go:** 00→11 at edge 0.
  - Required, edges 0..15: `audio` toggles every 4 cycles (0000111100001111).
  - Required, edges 16..31: `audio` toggles every 2 cycles.
  - Required: `busy` falls at edge 32.
- **Retrigger:** ping at edge 0, then `code_sound`=01 at edge 5.
  - Required: counters restart and `audio`=0 at edge 5.
  - Required: `audio` toggles every 4 cycles; `busy` falls at edge 21.
- **Mute:** go at edge 0, then `mute`=1 sampled at edge 10.
  - Required: `audio`=0 and `busy`=0 at edge 10.
  - Release `mute` at edge 20 with code still 11. Required: stays IDLE.
- **No replay:** hold `code_sound`=10 for 40 cycles after a ping. Required: one 16-cycle note only.
  - Then set 00 for 1 cycle and back to 10. Required: a new ping starts on the 00→10 edge.
- **Async reset:** `clr` pulsed mid-go, between clock edges. Required: `audio`=0 and `busy`=0 before the next edge, with no further toggles.
